ptr_sync_r2w: RTL and testbench
===============================

Name: ptr_sync_r2w

Overview:
- Parametrised read-to-write pointer synchroniser for the async FIFO, the successor of the fixed 4-bit, 2-flop version.
- Carries a Gray-coded read pointer into the wr_clk domain through a configurable flop chain, then decodes it to binary.
- Reports how many entries were freed since the last update, and flags illegal Gray transitions (multi-bit changes) as a sticky error.
- Feeds the write-side full/almost-full logic.

Parameters:
- PTR_W, 4, pointer width in bits (FIFO address width + 1); legal range 2..16.
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4. Elaboration error outside the range.

Ports:
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  asynchronous active-low reset, write domain
- rd_ptr_gray  in  PTR_W  Gray-coded read pointer, launched from the rd_clk domain
- err_clr  in  1  synchronous clear of gray_err
- wq_rd_ptr_gray  out  PTR_W  synchronised Gray pointer
- wq_rd_ptr_bin  out  PTR_W  binary decode of wq_rd_ptr_gray
- rd_ptr_delta  out  PTR_W  entries freed since the previous update, modulo 2^PTR_W
- rd_ptr_adv  out  1  single-cycle pulse; rd_ptr_delta is valid this cycle
- ptr_valid  out  1  outputs are trustworthy after post-reset warm-up
- gray_err  out  1  sticky: two successive synchronised samples differed in more than one bit

Behaviour:
- Reset, asynchronous on wr_rst_n low:
  - All sync stages, the binary register, prev registers and the warm-up counter go to 0.
  - All outputs read 0: wq_rd_ptr_gray=0, wq_rd_ptr_bin=0, rd_ptr_delta=0, rd_ptr_adv=0, ptr_valid=0, gray_err=0.
  - Reset is released through the system-level reset synchroniser; this block does not re-synchronise it.
- Sync chain:
  - stage[0] <= rd_ptr_gray; stage[i] <= stage[i-1].
  - wq_rd_ptr_gray = stage[SYNC_STAGES-1].
  - Latency is SYNC_STAGES cycles. No logic is placed between stages.
- Decode:
  - wq_rd_ptr_bin is registered. b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
  - Latency is SYNC_STAGES+1 cycles from input.
- Delta and advance:
  - prev_bin holds the last decoded value.
  - Each cycle, rd_ptr_delta <= wq_rd_ptr_bin - prev_bin, modulo 2^PTR_W, so wrap-around is handled by unsigned subtraction.
  - rd_ptr_adv <= (delta != 0) && ptr_valid.
  - prev_bin <= wq_rd_ptr_bin.
  - Latency is SYNC_STAGES+2 cycles from input.
  - rd_ptr_delta holds its last value when rd_ptr_adv=0.
  - A delta of 2^PTR_W-1 is legal and is reported as-is.
- Warm-up:
  - A counter starts at reset release and saturates at SYNC_STAGES+2.
  - ptr_valid rises in the cycle the counter reaches SYNC_STAGES+2 and stays high until the next reset.
  - rd_ptr_adv and gray_err updates are suppressed while ptr_valid=0.
- Gray check:
  - prev_gray tracks wq_rd_ptr_gray.
  - When ptr_valid=1 and popcount(wq_rd_ptr_gray ^ prev_gray) > 1, set gray_err.
  - Zero-bit and one-bit changes are legal.
- Error clear:
  - err_clr=1 clears gray_err next cycle.
  - If a violation occurs in the same cycle as err_clr, the violation wins and gray_err stays 1.
- Reset mid-operation:
  - Immediate return to reset values. Any pending adv pulse is lost.
  - Warm-up restarts after release.
- Input contract: rd_ptr_gray changes by at most one bit per rd_clk edge.

Decomposition:
- Shared package fifo_sync_pkg:
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4
  - function gray2bin(PTR_W)
  - function gray_onehot_ok (popcount <= 1)
- One sub-module, sync_bus_ff (parametrised width and depth, flop chain only), reused by the future sync_w2r successor.
- This block instantiates sync_bus_ff and adds the decode, delta, warm-up and check logic.

Test Plan:
- Reset and warm-up (SYNC_STAGES=2): hold wr_rst_n=0 → all outputs 0. Release it → ptr_valid=1 exactly 4 wr_clk cycles later.
- Latency (PTR_W=4, SYNC_STAGES=2): after valid, step rd_ptr_gray 0000→0001 → wq_rd_ptr_gray=0001 after 2 cycles, wq_rd_ptr_bin=0001 after 3, rd_ptr_adv pulses once with delta=1 after 4.
- Burst and wrap: Gray-walk the binary pointer 13→14→15→0→1, one step per 3 wr_clk cycles → five adv pulses, each delta=1. Then jump the synchronised value bin 14→2 (Gray steps within one wr_clk) → delta=4.
- Gray violation: after valid, drive 0000→0011 → gray_err=1 at SYNC_STAGES+1 cycles. Pulse err_clr → gray_err=0 next cycle. Violation coincident with err_clr → gray_err stays 1.
- Mid-operation reset: assert wr_rst_n=0 during an adv pulse → outputs 0 asynchronously. After release, no adv and no gray_err during warm-up, even though the input is nonzero.
- Parameter sweep: PTR_W=6, SYNC_STAGES=3, full Gray walk of 64 steps → decode equals the reference binary, sum of deltas = 64, ptr_valid after 5 cycles.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO pointer synchronisers.
// Helpers operate at the widest legal pointer width; callers zero-extend and truncate.
package fifo_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PTR_W_MIN       = 2;
  localparam int PTR_W_MAX       = 16;

  // Zero-extended Gray input decodes to the zero-extended binary value.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic gray_onehot_ok(input logic [PTR_W_MAX-1:0] d);
    return (d & (d - 16'd1)) == '0;
  endfunction

endpackage

// File: rtl/sync_bus_ff.sv
// Plain multi-flop bus synchroniser: a chain of DEPTH registers with nothing in between.
// Shared by both pointer-crossing directions of the async FIFO.
module sync_bus_ff
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH < SYNC_STAGES_MIN) begin : g_bad_depth
      $error("sync_bus_ff: DEPTH must be at least %0d", SYNC_STAGES_MIN);
    end
  endgenerate

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/ptr_sync_r2w.sv
// Read-pointer crossing into the write clock domain: sync chain, Gray decode,
// freed-entry delta with advance pulse, warm-up qualification and sticky Gray check.
module ptr_sync_r2w
  import fifo_sync_pkg::*;
#(
  parameter int PTR_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic [PTR_W-1:0] rd_ptr_gray,
  input  logic             err_clr,
  output logic [PTR_W-1:0] wq_rd_ptr_gray,
  output logic [PTR_W-1:0] wq_rd_ptr_bin,
  output logic [PTR_W-1:0] rd_ptr_delta,
  output logic             rd_ptr_adv,
  output logic             ptr_valid,
  output logic             gray_err
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("ptr_sync_r2w: SYNC_STAGES=%0d outside %0d..%0d",
             SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
    if (PTR_W < PTR_W_MIN || PTR_W > PTR_W_MAX) begin : g_bad_width
      $error("ptr_sync_r2w: PTR_W=%0d outside %0d..%0d", PTR_W, PTR_W_MIN, PTR_W_MAX);
    end
  endgenerate

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 2);

  logic [PTR_W-1:0] gray_p0;
  logic [PTR_W-1:0] bin_p1;
  logic [PTR_W-1:0] prev_gray_p1;
  logic [PTR_W-1:0] prev_bin_p2;
  logic [PTR_W-1:0] delta_p2;
  logic [PTR_W-1:0] diff;
  logic             adv_p2;
  logic             err_q;
  logic             viol;
  logic [2:0]       warm_cnt;

  function automatic logic [2:0] warm_inc(input logic [2:0] c);
    return (c == WARM_DONE) ? c : c + 3'd1;
  endfunction

  // Stage 0: synchroniser chain, output is the last flop
  sync_bus_ff #(
    .WIDTH(PTR_W),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk  (wr_clk),
    .rst_n(wr_rst_n),
    .d    (rd_ptr_gray),
    .q    (gray_p0)
  );

  assign ptr_valid = (warm_cnt == WARM_DONE);
  // Unsigned subtraction wraps, so a pointer rollover still yields the freed count.
  assign diff      = bin_p1 - prev_bin_p2;
  assign viol      = ptr_valid && !gray_onehot_ok(PTR_W_MAX'(gray_p0 ^ prev_gray_p1));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      warm_cnt     <= '0;
      bin_p1       <= '0;
      prev_gray_p1 <= '0;
      prev_bin_p2  <= '0;
      delta_p2     <= '0;
      adv_p2       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      warm_cnt     <= warm_inc(warm_cnt);
      // Stage 1: registered decode
      bin_p1       <= PTR_W'(gray2bin(PTR_W_MAX'(gray_p0)));
      prev_gray_p1 <= gray_p0;
      // Stage 2: delta against the previous decode; delta holds between pulses
      prev_bin_p2  <= bin_p1;
      adv_p2       <= ptr_valid && (diff != '0);
      if (ptr_valid && (diff != '0)) begin
        delta_p2 <= diff;
      end
      // A violation in the same cycle as a clear keeps the flag set.
      if (viol) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wq_rd_ptr_gray = gray_p0;
  assign wq_rd_ptr_bin  = bin_p1;
  assign rd_ptr_delta   = delta_p2;
  assign rd_ptr_adv     = adv_p2;
  assign gray_err       = err_q;

endmodule

// File: tb/tb_ptr_sync_r2w.sv
// Bench for ptr_sync_r2w: two instances (4-bit/2-stage and 6-bit/3-stage) against a
// history-based reference model, plus a constant vector table and corner sequences.
module tb_ptr_sync_r2w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, clr0, adv0, vld0, err0;
  logic [3:0] g0, wq0, bin0, delta0;
  logic       rst1_n, clr1, adv1, vld1, err1;
  logic [5:0] g1, wq1, bin1, delta1;

  ptr_sync_r2w #(.PTR_W(4), .SYNC_STAGES(2)) dut0 (
    .wr_clk(clk), .wr_rst_n(rst0_n), .rd_ptr_gray(g0), .err_clr(clr0),
    .wq_rd_ptr_gray(wq0), .wq_rd_ptr_bin(bin0), .rd_ptr_delta(delta0),
    .rd_ptr_adv(adv0), .ptr_valid(vld0), .gray_err(err0)
  );

  ptr_sync_r2w #(.PTR_W(6), .SYNC_STAGES(3)) dut1 (
    .wr_clk(clk), .wr_rst_n(rst1_n), .rd_ptr_gray(g1), .err_clr(clr1),
    .wq_rd_ptr_gray(wq1), .wq_rd_ptr_bin(bin1), .rd_ptr_delta(delta1),
    .rd_ptr_adv(adv1), .ptr_valid(vld1), .gray_err(err1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the sampled input history since reset release; every
  // output is a function of that history (edge k sees input sampled at edge k).
  int SS[2]   = '{2, 3};
  int MASK[2] = '{15, 63};
  int gh[2][8192];
  int mn[2];
  int m_delta[2];
  int m_err[2];
  int m_adv[2];

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int in_at(int i, int k);
    if (k < 1 || k > mn[i]) return 0;
    return gh[i][k];
  endfunction

  function automatic int g2b(int i, int g);
    int b = 0;
    for (int s = 0; s < 16; s++) b = b ^ (g >> s);
    return b & MASK[i];
  endfunction

  function automatic int wq_m(int i, int k);
    return in_at(i, k - SS[i] + 1);
  endfunction

  function automatic int bin_m(int i, int k);
    return g2b(i, in_at(i, k - SS[i]));
  endfunction

  task automatic model_step(input int i, input int g, input bit clr, input bit rst_n);
    int  diff;
    bit  vprev;
    if (!rst_n) begin
      mn[i] = 0; m_delta[i] = 0; m_err[i] = 0; m_adv[i] = 0;
      return;
    end
    if (mn[i] < 8191) mn[i]++;
    gh[i][mn[i]] = g;
    vprev = (mn[i] - 1) >= SS[i] + 2;
    diff  = (bin_m(i, mn[i] - 1) - bin_m(i, mn[i] - 2)) & MASK[i];
    m_adv[i] = (vprev && diff != 0) ? 1 : 0;
    if (m_adv[i] != 0) m_delta[i] = diff;
    if (vprev && $countones(wq_m(i, mn[i] - 1) ^ wq_m(i, mn[i] - 2)) > 1) m_err[i] = 1;
    else if (clr) m_err[i] = 0;
  endtask

  task automatic tick();
    int s0, s1;
    bit c0, c1, r0, r1;
    @(posedge clk);
    s0 = int'(g0); c0 = clr0; r0 = rst0_n;
    s1 = int'(g1); c1 = clr1; r1 = rst1_n;
    model_step(0, s0, c0, r0);
    model_step(1, s1, c1, r1);
    #1;
    check("m0.wq",    32'(wq0),    wq_m(0, mn[0]));
    check("m0.bin",   32'(bin0),   bin_m(0, mn[0]));
    check("m0.delta", 32'(delta0), m_delta[0]);
    check("m0.adv",   32'(adv0),   m_adv[0]);
    check("m0.vld",   32'(vld0),   32'(mn[0] >= SS[0] + 2));
    check("m0.err",   32'(err0),   m_err[0]);
    check("m1.wq",    32'(wq1),    wq_m(1, mn[1]));
    check("m1.bin",   32'(bin1),   bin_m(1, mn[1]));
    check("m1.delta", 32'(delta1), m_delta[1]);
    check("m1.adv",   32'(adv1),   m_adv[1]);
    check("m1.vld",   32'(vld1),   32'(mn[1] >= SS[1] + 2));
    check("m1.err",   32'(err1),   m_err[1]);
  endtask

  typedef struct {
    int g; int clr; int wq; int bin; int adv; int delta; int vld; int err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int g, int clr, int wq, int bin, int adv, int delta, int vld, int err);
    vec_t v;
    v.g = g; v.clr = clr; v.wq = wq; v.bin = bin;
    v.adv = adv; v.delta = delta; v.vld = vld; v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, d1, jd, sum;
    bit got;

    // Rows start at the first edge after reset release (PTR_W=4, SYNC_STAGES=2).
    //                g  clr wq bin adv dlt vld err
    tbl.push_back(mk(0, 0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(mk(0, 0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(mk(0, 0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(mk(0, 0,  0, 0,  0,  0,  1,  0));
    tbl.push_back(mk(1, 0,  0, 0,  0,  0,  1,  0));
    tbl.push_back(mk(1, 0,  1, 0,  0,  0,  1,  0));
    tbl.push_back(mk(1, 0,  1, 1,  0,  0,  1,  0));
    tbl.push_back(mk(1, 0,  1, 1,  1,  1,  1,  0));
    tbl.push_back(mk(1, 0,  1, 1,  0,  1,  1,  0));
    tbl.push_back(mk(0, 0,  1, 1,  0,  1,  1,  0));
    tbl.push_back(mk(0, 0,  0, 1,  0,  1,  1,  0));
    tbl.push_back(mk(3, 0,  0, 0,  0,  1,  1,  0));
    tbl.push_back(mk(3, 0,  3, 0,  1, 15,  1,  0));
    tbl.push_back(mk(3, 0,  3, 2,  0, 15,  1,  1));
    tbl.push_back(mk(3, 1,  3, 2,  1,  2,  1,  0));
    tbl.push_back(mk(3, 0,  3, 2,  0,  2,  1,  0));
    tbl.push_back(mk(0, 0,  3, 2,  0,  2,  1,  0));
    tbl.push_back(mk(0, 0,  0, 2,  0,  2,  1,  0));
    tbl.push_back(mk(0, 1,  0, 0,  0,  2,  1,  1));
    tbl.push_back(mk(0, 0,  0, 0,  1, 14,  1,  1));
    tbl.push_back(mk(0, 0,  0, 0,  0, 14,  1,  1));

    rst0_n = 1'b0; rst1_n = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    g0 = 4'hA; g1 = 6'h15;
    repeat (3) tick();
    check("rst.wq",  32'(wq0),  0);
    check("rst.vld", 32'(vld0), 0);

    g0 = 4'h0;
    rst0_n = 1'b1;
    for (int r = 0; r < tbl.size(); r++) begin
      g0   = 4'(tbl[r].g);
      clr0 = (tbl[r].clr != 0);
      tick();
      check("tbl.wq",    32'(wq0),    tbl[r].wq);
      check("tbl.bin",   32'(bin0),   tbl[r].bin);
      check("tbl.adv",   32'(adv0),   tbl[r].adv);
      check("tbl.delta", 32'(delta0), tbl[r].delta);
      check("tbl.vld",   32'(vld0),   tbl[r].vld);
      check("tbl.err",   32'(err0),   tbl[r].err);
    end
    clr0 = 1'b0;

    // Burst across the wrap: 12 settles, then 13,14,15,0,1 one step per 3 cycles.
    clr0 = 1'b1; g0 = 4'(gray_of(12)); tick(); clr0 = 1'b0;
    repeat (8) tick();
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    pulses = 0; d1 = 0;
    for (int s = 13; s <= 17; s++) begin
      g0 = 4'(gray_of(s & 15));
      repeat (3) begin
        tick();
        if (adv0) begin pulses++; if (delta0 == 4'd1) d1++; end
      end
    end
    repeat (6) begin
      tick();
      if (adv0) begin pulses++; if (delta0 == 4'd1) d1++; end
    end
    check("burst.pulses", 32'(pulses), 5);
    check("burst.delta1", 32'(d1), 5);

    // Several Gray steps inside one wr_clk period: 14 -> 2 seen as one jump.
    g0 = 4'(gray_of(14));
    repeat (8) tick();
    g0 = 4'(gray_of(15)); #1;
    g0 = 4'(gray_of(0));  #1;
    g0 = 4'(gray_of(1));  #1;
    g0 = 4'(gray_of(2));
    got = 1'b0; jd = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (adv0 && !got) begin got = 1'b1; jd = int'(delta0); end
    end
    check("jump.adv", 32'(got), 1);
    check("jump.delta", 32'(jd), 4);

    // Reset asserted while an advance pulse is on the outputs.
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    g0 = 4'(gray_of(3));
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (adv0) begin got = 1'b1; break; end
    end
    check("midrst.adv_seen", 32'(got), 1);
    #2 rst0_n = 1'b0;
    #1;
    check("midrst.wq",    32'(wq0),    0);
    check("midrst.bin",   32'(bin0),   0);
    check("midrst.delta", 32'(delta0), 0);
    check("midrst.adv",   32'(adv0),   0);
    check("midrst.vld",   32'(vld0),   0);
    check("midrst.err",   32'(err0),   0);
    repeat (2) tick();
    g0 = 4'b0110;
    rst0_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("warm.adv", 32'(adv0), 0);
      check("warm.err", 32'(err0), 0);
      check("warm.vld", 32'(vld0), 32'(k >= 4));
    end
    repeat (4) tick();

    // Second configuration: warm-up length and a full 64-step Gray walk.
    g1 = 6'h0;
    rst1_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sweep.vld", 32'(vld1), 32'(k == 5));
    end
    sum = 0;
    for (int s = 1; s <= 64; s++) begin
      g1 = 6'(gray_of(s & 63));
      repeat (2) begin
        tick();
        if (adv1) sum += int'(delta1);
      end
    end
    repeat (6) begin
      tick();
      if (adv1) sum += int'(delta1);
    end
    check("sweep.sum", 32'(sum), 64);

    // Random mostly-legal traffic on both instances, occasional illegal jumps and clears.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 8) g0 = g0 ^ (4'b1 << $urandom_range(0, 3));
      else if (r == 15) g0 = 4'($urandom);
      r = int'($urandom_range(0, 15));
      if (r < 8) g1 = g1 ^ (6'b1 << $urandom_range(0, 5));
      else if (r == 15) g1 = 6'($urandom);
      clr0 = ($urandom_range(0, 7) == 0);
      clr1 = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
